// File: rtl/ttrng_pkg.sv
// Shared mode encodings, default generator constants and the generator step function
// for the ttrng pseudo-random source.
package ttrng_pkg;

    localparam logic [1:0] MODE_CNT   = 2'b00;
    localparam logic [1:0] MODE_LFSR  = 2'b01;
    localparam logic [1:0] MODE_XS    = 2'b10;
    localparam logic [1:0] MODE_PAUSE = 2'b11;

    localparam int         STEP_W   = 64;
    localparam logic [15:0] DEF_SEED = 16'hACE1;
    localparam logic [15:0] DEF_TAPS = 16'hB400;

    // Works on a STEP_W-wide container; w selects the live generator width so one
    // function serves every LFSR_W up to STEP_W.
    function automatic logic [STEP_W-1:0] step_fn(
        input logic [1:0]        mode,
        input logic [STEP_W-1:0] s,
        input int                w,
        input logic [STEP_W-1:0] taps,
        input int                a,
        input int                b,
        input int                c
    );
        logic [STEP_W-1:0] mask;
        logic [STEP_W-1:0] t;
        mask = (w >= STEP_W) ? '1 : ((64'd1 << w) - 64'd1);
        t    = s & mask;
        case (mode)
            MODE_CNT:  t = (t + 64'd1) & mask;
            MODE_LFSR: t = t[0] ? (((t >> 1) ^ taps) & mask) : (t >> 1);
            MODE_XS: begin
                t = t ^ ((t << a) & mask);
                t = t ^ (t >> b);
                t = t ^ ((t << c) & mask);
            end
            default: t = t;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ttrng_fifo.sv
// Power-of-two output buffer with exact occupancy and synchronous flush.
// Pushes into a full buffer are dropped unless a pop happens in the same cycle.
module ttrng_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign level   = count;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ttrng_gen.sv
// Multi-mode pseudo-random generator feeding a small output buffer; the generator
// stalls instead of dropping words when the buffer is full.
module ttrng_gen
    import ttrng_pkg::*;
#(
    parameter int                WIDTH  = 8,
    parameter int                LFSR_W = 16,
    parameter int                DEPTH  = 4,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED),
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
    parameter int                XS_A   = 7,
    parameter int                XS_B   = 9,
    parameter int                XS_C   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [1:0]                 mode,
    input  logic [LFSR_W-1:0]          seed_in,
    input  logic                       seed_load,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           number,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    // Handshake: number/valid present the buffer head; a word is consumed on a rising
    // edge where valid && rd_en. rd_en while valid is low has no effect, and
    // seed_load overrides both the pop and any push in that cycle.

    logic [LFSR_W-1:0] state;
    logic [LFSR_W-1:0] state_step;
    logic [STEP_W-1:0] step_full;
    logic              unused_step;
    logic              empty;
    logic              full;
    logic              pop;
    logic              adv;

    assign step_full   = step_fn(mode, STEP_W'(state), LFSR_W, STEP_W'(TAPS), XS_A, XS_B, XS_C);
    assign state_step  = step_full[LFSR_W-1:0];
    assign unused_step = ^step_full;

    assign valid = ~empty;
    assign pop   = rd_en & valid & ~seed_load;
    assign adv   = ena & (mode != MODE_PAUSE) & (~full | pop) & ~seed_load;

    // A zero seed would lock the LFSR and xorshift modes, so it falls back to SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (seed_load) begin
            state <= (seed_in == '0) ? SEED : seed_in;
        end else if (adv) begin
            state <= state_step;
        end
    end

    ttrng_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (adv),
        .pop   (pop),
        .flush (seed_load),
        .din   (state_step[WIDTH-1:0]),
        .dout  (number),
        .level (level),
        .empty (empty),
        .full  (full)
    );

endmodule

// File: tb/tb_ttrng_gen.sv
// Bench for ttrng_gen: directed scenarios plus random traffic, scored against a
// queue-based reference of the generator and its output buffer.
module tb_ttrng_gen;

    localparam int          WIDTH = 8;
    localparam int          DEPTH = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] seed_in = 16'h0000;
    logic        seed_load = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  number;
    logic        valid;
    logic [2:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: generator state plus the words the buffer should hold, oldest first.
    logic [15:0]      m_state = SEED;
    int               m_level = 0;
    logic [WIDTH-1:0] exp_q[$];

    ttrng_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mode      (mode),
        .seed_in   (seed_in),
        .seed_load (seed_load),
        .rd_en     (rd_en),
        .number    (number),
        .valid     (valid),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [1:0] m, input logic [15:0] s);
        logic [15:0] x;
        x = s;
        case (m)
            2'b00: x = s + 16'd1;
            2'b01: x = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
            2'b10: begin
                x = x ^ (x << 7);
                x = x ^ (x >> 9);
                x = x ^ (x << 8);
            end
            default: x = s;
        endcase
        return x;
    endfunction

    // Apply the rules for the edge that just happened, using the inputs held across it.
    task automatic model_update();
        bit do_pop;
        bit do_adv;
        if (!rst_n) return;
        if (seed_load) begin
            m_state = (seed_in == 16'h0) ? SEED : seed_in;
            exp_q.delete();
            m_level = 0;
        end else begin
            do_pop = rd_en && (m_level > 0);
            do_adv = ena && (mode != 2'b11) && ((m_level < DEPTH) || do_pop);
            if (do_pop) m_level--;
            if (do_adv) begin
                m_state = ref_step(mode, m_state);
                exp_q.push_back(m_state[WIDTH-1:0]);
                m_level++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_state = SEED;
        m_level = 0;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_inputs(input logic e, input logic [1:0] m, input logic r);
        ena = e;
        mode = m;
        rd_en = r;
        seed_load = 1'b0;
        seed_in = 16'h0;
    endtask

    // Monitor: checks occupancy every cycle and scores each consumed word.
    always @(negedge clk) begin
        if (rst_n) begin
            check("level", 32'(level), 32'(m_level));
            check("valid", 32'(valid), 32'(m_level != 0));
            if (valid && rd_en && !seed_load) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_word: got 0x%0h, expected no word (model empty) at %0t", number, $time);
                end else begin
                    check("pop_word", 32'(number), 32'(exp_q.pop_front()));
                end
            end else if (!valid) begin
                check("empty_number", 32'(number), 32'h0);
            end
        end
    end

    initial begin
        // 1: LFSR sequence straight out of reset
        set_inputs(1'b1, 2'b01, 1'b1);
        do_reset();
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_number", 32'(number), 32'h0);
        tick(); check("lfsr_0", 32'(number), 32'h70); check("lfsr_valid", 32'(valid), 32'h1);
        tick(); check("lfsr_1", 32'(number), 32'h38);
        tick(); check("lfsr_2", 32'(number), 32'h9C);

        // 2: counter and xorshift first words
        set_inputs(1'b1, 2'b00, 1'b1);
        do_reset();
        tick(); check("cnt_0", 32'(number), 32'hE2);
        tick(); check("cnt_1", 32'(number), 32'hE3);
        set_inputs(1'b1, 2'b10, 1'b1);
        do_reset();
        tick(); check("xs_0", 32'(number), 32'h0F);

        // 3: fill to full, hold, then pop once while full
        set_inputs(1'b1, 2'b01, 1'b0);
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            tick(); check("fill_level", 32'(level), 32'(i));
        end
        tick(); tick(); check("full_hold", 32'(level), 32'(DEPTH));
        check("full_head", 32'(number), 32'h70);
        rd_en = 1'b1;
        tick(); rd_en = 1'b0;
        check("pop_full_level", 32'(level), 32'(DEPTH));
        check("pop_full_head", 32'(number), 32'h38);

        // 4: zero seed falls back to SEED and flushes the buffer
        set_inputs(1'b1, 2'b01, 1'b0);
        do_reset();
        tick(); tick(); tick();
        seed_in = 16'h0; seed_load = 1'b1; ena = 1'b1;
        tick();
        seed_load = 1'b0; ena = 1'b0;
        check("flush_level", 32'(level), 32'h0);
        check("flush_valid", 32'(valid), 32'h0);
        ena = 1'b1;
        tick(); check("seed_fallback", 32'(number), 32'h70);

        // 5: ena low drains without pushing, then resumes without a gap
        set_inputs(1'b1, 2'b01, 1'b0);
        do_reset();
        tick(); tick();
        ena = 1'b0; rd_en = 1'b1;
        tick(); tick(); tick();
        check("drain_valid", 32'(valid), 32'h0);
        ena = 1'b1;
        tick(); check("resume", 32'(number), 32'h9C);

        // 6: asynchronous reset in the middle of a burst
        set_inputs(1'b1, 2'b01, 1'b0);
        do_reset();
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        m_state = SEED; m_level = 0; exp_q.delete();
        #1;
        check("async_valid", 32'(valid), 32'h0);
        check("async_level", 32'(level), 32'h0);
        check("async_number", 32'(number), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_en = 1'b1;
        tick(); check("restart", 32'(number), 32'h70);

        // Random traffic scored by the monitor
        for (int i = 0; i < 600; i++) begin
            ena       = ($urandom_range(0, 9) < 8);
            mode      = 2'($urandom_range(0, 3));
            rd_en     = ($urandom_range(0, 1) == 1);
            seed_load = ($urandom_range(0, 99) < 3);
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(0, 65535));
            tick();
        end

        set_inputs(1'b0, 2'b11, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
